// File: rtl/pipe_debug_ctrl.sv
// pipe_debug_ctrl: halts fetch on breakpoint/timeout, drains the pipe, streams r0-r31 out
module pipe_debug_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16,
    parameter int CYCLE_LIMIT  = 1000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      pc,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic             resume,
    input  logic [31:0]      reg_data,
    input  logic             dump_ready,
    output logic             cpu_stall,
    output logic [4:0]       reg_sel,
    output logic             dump_valid,
    output logic [31:0]      dump_data,
    output logic [4:0]       dump_idx,
    output logic             halted,
    output logic             bp_hit,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);
    typedef enum logic [2:0] {RUN, DRAIN, SEL, SEND, HOLD} state_t;
    state_t state, state_nx;
    logic [3:0] drain_cnt;
    logic [4:0] idx;
    logic bp_mask, bp_cond, to_cond, drain_done;
    assign bp_cond = bp_en && (pc == bp_addr) && !bp_mask;
    assign to_cond = (CYCLE_LIMIT != 0) && (cycle_count == CNT_W'(CYCLE_LIMIT - 1));
    assign drain_done = drain_cnt == 4'(DRAIN_CYCLES - 1);
    assign reg_sel = idx;
    // next state and state-decoded outputs
    always_comb begin
        state_nx = state;
        cpu_stall = state != RUN;
        halted = state == HOLD;
        dump_valid = state == SEND;
        case (state)
            RUN:     state_nx = (bp_cond || to_cond) ? DRAIN : RUN;
            DRAIN:   state_nx = drain_done ? SEL : DRAIN;
            SEL:     state_nx = SEND;
            SEND:    state_nx = dump_ready ? ((idx == 5'd31) ? HOLD : SEL) : SEND;
            HOLD:    state_nx = resume ? RUN : HOLD;
            default: state_nx = RUN;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RUN;
        else state <= state_nx;
    end
    // counters, flags, register index and captured dump beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drain_cnt   <= '0;
            idx         <= '0;
            bp_mask     <= 1'b0;
            bp_hit      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            dump_data   <= '0;
            dump_idx    <= '0;
        end else begin
            case (state)
                RUN: begin
                    cycle_count <= cycle_count + CNT_W'(cycle_count != '1);
                    if (pc != bp_addr) bp_mask <= 1'b0;
                    if (bp_cond) bp_hit <= 1'b1;
                    if (to_cond) timeout <= 1'b1;
                end
                DRAIN: begin
                    drain_cnt <= drain_done ? 4'd0 : drain_cnt + 4'd1;
                    idx <= '0;
                end
                SEL: begin
                    dump_data <= (idx == 5'd0) ? 32'd0 : reg_data;
                    dump_idx  <= idx;
                end
                SEND: if (dump_ready && idx != 5'd31) idx <= idx + 5'd1;
                HOLD: if (resume) begin
                    bp_hit      <= 1'b0;
                    timeout     <= 1'b0;
                    cycle_count <= '0;
                    bp_mask     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// tb_pipe_debug_ctrl: scenario table plus hand sequences for resume and mid-dump reset
module tb_pipe_debug_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc, bp_addr, reg_data, dump_data;
    logic        bp_en, resume, dump_ready, cpu_stall, dump_valid, halted, bp_hit, timeout;
    logic [4:0]  reg_sel, dump_idx;
    logic [15:0] cycle_count;
    logic [31:0] rf [32];
    int n_cmp = 0, n_err = 0;

    typedef struct {
        logic        bp_en;
        logic [31:0] bp_addr;
        logic [3:0]  ready_pat;
        int          exp_trig;
        logic        exp_bp;
        logic        exp_to;
    } scen_t;
    scen_t tbl[5];

    pipe_debug_ctrl dut (
        .clk(clk), .rstn(rstn), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .resume(resume), .reg_data(reg_data), .dump_ready(dump_ready),
        .cpu_stall(cpu_stall), .reg_sel(reg_sel), .dump_valid(dump_valid),
        .dump_data(dump_data), .dump_idx(dump_idx), .halted(halted),
        .bp_hit(bp_hit), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;
    assign reg_data = rf[reg_sel];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk(nm, 64'({cpu_stall, reg_sel, dump_valid, dump_data, dump_idx, halted,
                     bp_hit, timeout, cycle_count}), 64'd0);
    endtask

    task automatic do_reset(input logic en, input logic [31:0] addr);
        rstn = 1'b0; resume = 1'b0; dump_ready = 1'b0; pc = '0;
        bp_en = en; bp_addr = addr;
        @(posedge clk); #1;
        chk_zero_outputs("reset_outputs");
        rstn = 1'b1;
    endtask

    task automatic run_to_trigger(input int exp_trig);
        int k;
        logic [15:0] cc_before = '0;
        for (k = 0; k < 2000; k++) begin
            pc = 32'(4 * k);
            cc_before = cycle_count;
            @(posedge clk); #1;
            if (cpu_stall) break;
        end
        chk("trig_cycle", 64'(k), 64'(exp_trig));
        chk("trig_count", 64'(cc_before), 64'(exp_trig));
    endtask

    task automatic run_dump(input int s);
        int t, nb = 0;
        bit pend = 0, stall_ok = 1;
        logic [36:0] held = '0;
        for (t = 1; t <= 400; t++) begin
            dump_ready = tbl[s].ready_pat[t % 4];
            resume = (s == 0 && t == 2);
            if (dump_valid) begin
                if (pend) chk("stable_while_stalled", 64'({dump_idx, dump_data}), 64'(held));
                pend = !dump_ready;
                held = {dump_idx, dump_data};
                if (dump_ready) begin
                    chk("beat_idx", 64'(dump_idx), 64'(nb));
                    chk("beat_data", 64'(dump_data), (nb == 0) ? 64'd0 : 64'(rf[nb[4:0]]));
                    nb++;
                end
            end
            stall_ok &= cpu_stall;
            @(posedge clk); #1;
            resume = 1'b0;
            if (halted) break;
        end
        chk("beat_count", 64'(nb), 64'd32);
        chk("halted", 64'(halted), 64'd1);
        if (tbl[s].ready_pat == 4'hF) chk("halt_latency", 64'(t), 64'd68);
        chk("stall_continuous", 64'(stall_ok), 64'd1);
        chk("flags", 64'({bp_hit, timeout}), 64'({tbl[s].exp_bp, tbl[s].exp_to}));
        chk("valid_low_in_hold", 64'(dump_valid), 64'd0);
    endtask

    initial begin
        rstn = 1'b0; resume = 1'b0; dump_ready = 1'b0; pc = '0; bp_en = 1'b0; bp_addr = '0;
        rf[0] = 32'hDEAD_BEEF;
        for (int i = 1; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0203;
        tbl[0] = '{1'b1, 32'h0000_0080, 4'b1111, 32,  1'b1, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0080, 4'b1111, 999, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 32'h0000_0F9C, 4'b1111, 999, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 32'h0000_0080, 4'b1001, 32,  1'b1, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_0000, 4'b1111, 0,   1'b1, 1'b0};
        for (int s = 0; s < 5; s++) begin
            do_reset(tbl[s].bp_en, tbl[s].bp_addr);
            run_to_trigger(tbl[s].exp_trig);
            run_dump(s);
            if (s == 0) begin
                resume = 1'b1;
                chk("stall_before_resume_edge", 64'(cpu_stall), 64'd1);
                @(posedge clk); #1;
                resume = 1'b0;
                chk("stall_after_resume", 64'(cpu_stall), 64'd0);
                chk("halted_after_resume", 64'(halted), 64'd0);
                chk("flags_after_resume", 64'({bp_hit, timeout}), 64'd0);
                chk("count_after_resume", 64'(cycle_count), 64'd0);
                repeat (5) begin
                    @(posedge clk); #1;
                end
                chk("no_retrigger", 64'(cpu_stall), 64'd0);
                chk("count_runs_again", 64'(cycle_count), 64'd5);
                pc = 32'h84;
                @(posedge clk); #1;
                pc = 32'h80;
                @(posedge clk); #1;
                chk("rearmed_trigger", 64'(cpu_stall), 64'd1);
                chk("rearmed_bp_hit", 64'(bp_hit), 64'd1);
            end
        end
        do_reset(1'b1, 32'h80);
        run_to_trigger(32);
        for (int c = 0; c < 200; c++) begin
            if (dump_valid && dump_idx == 5'd12) break;
            dump_ready = 1'b1;
            @(posedge clk); #1;
        end
        dump_ready = 1'b0;
        chk("midsend_idx", 64'(dump_idx), 64'd12);
        chk("midsend_valid", 64'(dump_valid), 64'd1);
        #3 rstn = 1'b0;
        #1 chk_zero_outputs("async_reset_outputs");
        @(posedge clk); #1;
        bp_en = 1'b0; pc = 32'h200; rstn = 1'b1;
        @(posedge clk); #1;
        chk("run_after_reset_stall", 64'({cpu_stall, dump_valid, halted}), 64'd0);
        chk("run_after_reset_count", 64'(cycle_count), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_debug_ctrl.md
# pipe_debug_ctrl

Debug sequencer for the five-stage pipelined MIPS core in `pipecomp`. It watches the fetch PC and halts instruction fetch on a PC breakpoint or a cycle-limit timeout. It waits for in-flight instructions to retire, then walks `reg_sel` over r0–r31 and streams each register value out over a valid/ready port. The bench or an on-chip UART logger consumes the stream; the core resumes on command.

## Interface
- `DRAIN_CYCLES`, default 4: cycles allowed for in-flight instructions to retire after fetch freezes; legal range 1–15.
- `CNT_W`, default 16: width of the run-cycle counter.
- `CYCLE_LIMIT`, default 1000: RUN cycles before a forced halt; 0 disables the timeout.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `pc`  in  32  current fetch PC from the IF stage.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  32  breakpoint PC.
- `resume`  in  1  single-cycle pulse; leaves HOLD.
- `reg_data`  in  32  combinational register-file read port data for `reg_sel`.
- `dump_ready`  in  1  consumer accepts `dump_data`.
- `cpu_stall`  out  1  freezes PC and IF/ID only; later stages keep retiring.
- `reg_sel`  out  5  register-file debug read address.
- `dump_valid`  out  1  `dump_data` / `dump_idx` valid.
- `dump_data`  out  32  captured register value.
- `dump_idx`  out  5  register number of `dump_data`.
- `halted`  out  1  high in HOLD.
- `bp_hit`  out  1  sticky; this halt was caused by the breakpoint.
- `timeout`  out  1  sticky; this halt was caused by the cycle limit.
- `cycle_count`  out  `CNT_W`  RUN cycles since reset or last resume; saturates at all-ones.

## Operation
- FSM states: RUN, DRAIN, SEL, SEND, HOLD. Reset state is RUN.
- Reset values: every output 0; internal drain counter and register index 0.
- RUN:
  - `cycle_count` increments each cycle.
  - Bp condition: `bp_en` and `pc == bp_addr`. It sets `bp_hit`.
  - Timeout condition: `CYCLE_LIMIT != 0` and `cycle_count == CYCLE_LIMIT-1`. It sets `timeout`.
  - Either condition moves the FSM to DRAIN. If both occur in the same cycle, set both flags.
- DRAIN:
  - `cpu_stall` = 1; the drain counter runs from 0 to `DRAIN_CYCLES-1`.
  - After that, go to SEL with index 0.
  - `bp_en`, `pc` and `resume` are ignored.
- SEL (one cycle per register): `reg_sel` = index; go to SEND.
- SEND:
  - On entry, `dump_data` is captured from `reg_data`; for index 0 it is forced to 0 regardless of `reg_data`. `dump_idx` = index, `dump_valid` = 1.
  - `dump_data` and `dump_idx` stay stable while `dump_valid` is high and `dump_ready` is low.
  - On `dump_valid && dump_ready`: for index < 31, increment the index and go to SEL; for index 31, go to HOLD.
- HOLD:
  - `halted` = 1, `cpu_stall` = 1, `dump_valid` = 0.
  - On `resume`: clear `bp_hit`, `timeout` and `cycle_count`, drop `cpu_stall`, go to RUN.
- `resume` outside HOLD is ignored. `dump_ready` while `dump_valid` is low is ignored.
- After resume, a PC still equal to `bp_addr` does not re-trigger until the PC has changed at least once.
- `reg_sel` holds its last value outside SEL/SEND.
- Reset mid-dump: immediate return to RUN with reset values; no partial-frame recovery.

## Timing
- Breakpoint latency: a match sampled at edge N gives `cpu_stall` = 1 after edge N. The matching instruction is fetched; nothing after it is.
- DRAIN lasts exactly `DRAIN_CYCLES` cycles.
- With `dump_ready` held high:
  - each register takes 2 cycles (SEL + SEND);
  - a full dump takes 64 cycles;
  - `halted` rises `DRAIN_CYCLES + 64` cycles after `cpu_stall` rises.
- `cpu_stall` stays high continuously from DRAIN through HOLD. It falls on the edge that samples `resume`.

## Test plan
- Breakpoint, `bp_en`=1, `bp_addr`=0x00000080, `dump_ready`=1 → `cpu_stall` one cycle after `pc`=0x80; 32 beats with `dump_idx` 0..31 in order; `dump_idx`=0 carries 0; each beat equals the `rf[n]` preload; `halted` after 4+64 cycles; `bp_hit`=1, `timeout`=0.
- Timeout, `bp_en`=0, `CYCLE_LIMIT`=1000 → `cpu_stall` rises after `cycle_count`=999; `timeout`=1, `bp_hit`=0.
- Simultaneous breakpoint and timeout on the same cycle → both flags 1; a single dump.
- Backpressure: `dump_ready` toggles 1-0-0-1 → no beat lost or duplicated; `dump_data` stable while stalled; 32 accepted beats.
- Resume: pulse `resume` in HOLD → flags and `cycle_count` clear; `cpu_stall` falls on the next edge; no re-trigger while `pc` stays 0x80; a `resume` pulse during DRAIN is ignored.
- Reset mid-SEND at `dump_idx`=12 → all outputs 0 asynchronously; FSM in RUN after release.
